rnd_checker: RTL

RND_CHECKER -- requirements
Module: rnd_checker

---
 rtl/rnd_checker_pkg.sv | 17 +
 rtl/rnd_lfsr_step.sv | 28 ++
 rtl/rnd_checker.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rnd_checker_pkg.sv
// rnd_checker_pkg
// Shared definitions for the pseudo-random symbol checker:
//   state_t  - checker FSM states (IDLE, ACQUIRE, LOCKED)
//   TAP_MASK - feedback taps of the 6-bit generator (bits 5, 3, 1)
//   ACQ_LEN  - symbols needed to reconstruct a full generator state
package rnd_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [5:0]  TAP_MASK = 6'b101010;
    localparam int unsigned ACQ_LEN  = 5;

endpackage

// File: rtl/rnd_lfsr_step.sv
// rnd_lfsr_step
// Combinational generator step: nxt = L^STEPS(cur), where
// L(S) = {S[W-2:0], ^(S & TAP_MASK)}.
// Parameters: W (register width, 6 only), STEPS (number of applications).
// Ports:
//   cur - current generator state
//   nxt - state after STEPS advances
module rnd_lfsr_step
    import rnd_checker_pkg::*;
#(
    parameter int unsigned W     = 6,
    parameter int unsigned STEPS = 1
) (
    input  logic [W-1:0] cur,
    output logic [W-1:0] nxt
);

    logic [W-1:0] v;

    always_comb begin
        v = cur;
        for (int unsigned i = 0; i < STEPS; i++) begin
            v = {v[W-2:0], ^(v & TAP_MASK)};
        end
        nxt = v;
    end

endmodule

// File: rtl/rnd_checker.sv
// rnd_checker
// Acquires the state of a 6-bit generator from its 2-bit symbol stream,
// then flywheels a local copy and flags mispredicted symbols.
// Build option: define RND_CHECKER_OVERLAP_EN to cross-check the redundant
// symbol bit during acquisition (sym[1] must equal the previous sym[0]).
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   en        - checking enable; low returns to IDLE
//   sym_valid - sym qualifier
//   sym       - received symbol {x[5], x[4]}
//   clear     - synchronous clear of err_cnt (wins over a mismatch)
//   locked    - high while in LOCKED
//   err_pulse - one-cycle pulse after a mispredicted symbol
//   lost      - one-cycle pulse on loss of lock
//   err_cnt   - saturating count of mispredictions
module rnd_checker
    import rnd_checker_pkg::*;
#(
    parameter int unsigned REG_WIDTH  = 6,
    parameter int unsigned ERR_WIDTH  = 4,
    parameter int unsigned MISS_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sym_valid,
    input  logic [1:0]           sym,
    input  logic                 clear,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 lost,
    output logic [ERR_WIDTH-1:0] err_cnt
);

    localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);
    localparam int unsigned CNT_W  = $clog2(ACQ_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACQ_LEN - 1);

    state_t                 state, state_n;
    logic [REG_WIDTH-1:0]   acq, acq_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [REG_WIDTH-1:0]   shadow, shadow_n;
    logic [MISS_W-1:0]      miss, miss_n, miss_inc;
    logic [ERR_WIDTH-1:0]   err_n;
    logic                   err_pulse_n, lost_n;

    logic [REG_WIDTH-1:0]   shadow_step;
    logic [REG_WIDTH-1:0]   acq_done;
    logic [REG_WIDTH-1:0]   acq_ff;
    logic [2:0]             lsb_idx;

    // Symbol k (k>=1) carries bit A[4-k] in its LSB; the final symbol
    // completes A[0], so the completed state is formed here directly.
    assign lsb_idx  = 3'(ACQ_LEN - 1) - cnt;
    assign acq_done = {acq[REG_WIDTH-1:1], sym[0]};
    assign miss_inc = miss + 1'b1;

    rnd_lfsr_step #(.W(REG_WIDTH), .STEPS(1)) u_flywheel (
        .cur (shadow),
        .nxt (shadow_step)
    );

    // Fast-forward from the first captured state to the one whose
    // {S[4],S[3]} predicts the next incoming symbol.
    rnd_lfsr_step #(.W(REG_WIDTH), .STEPS(ACQ_LEN - 1)) u_fastfwd (
        .cur (acq_done),
        .nxt (acq_ff)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            acq       <= '0;
            cnt       <= '0;
            shadow    <= '0;
            miss      <= '0;
            err_cnt   <= '0;
            err_pulse <= 1'b0;
            lost      <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state     <= state_n;
            acq       <= acq_n;
            cnt       <= cnt_n;
            shadow    <= shadow_n;
            miss      <= miss_n;
            err_cnt   <= err_n;
            err_pulse <= err_pulse_n;
            lost      <= lost_n;
            locked    <= (state_n == ST_LOCKED);
        end
    end

    always_comb begin
        state_n     = state;
        acq_n       = acq;
        cnt_n       = cnt;
        shadow_n    = shadow;
        miss_n      = miss;
        err_n       = err_cnt;
        err_pulse_n = 1'b0;
        lost_n      = 1'b0;

        if (!en) begin
            state_n = ST_IDLE;
            acq_n   = '0;
            cnt_n   = '0;
            miss_n  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n = ST_ACQUIRE;
                    acq_n   = '0;
                    cnt_n   = '0;
                    miss_n  = '0;
                    if (sym_valid) begin
                        acq_n[REG_WIDTH-1 -: 2] = sym;
                        cnt_n = CNT_W'(1);
                    end
                end

                ST_ACQUIRE: begin
                    if (sym_valid) begin
                        if (cnt == '0) begin
                            acq_n[REG_WIDTH-1 -: 2] = sym;
                            cnt_n = CNT_W'(1);
                        end
`ifdef RND_CHECKER_OVERLAP_EN
                        else if (sym[1] != acq[lsb_idx + 3'd1]) begin
                            acq_n[REG_WIDTH-1 -: 2] = sym;
                            cnt_n = CNT_W'(1);
                        end
`endif
                        else if (cnt == LAST_CNT) begin
                            if (acq_done == '0) begin
                                acq_n = '0;
                                cnt_n = '0;
                            end else begin
                                acq_n    = acq_done;
                                shadow_n = acq_ff;
                                state_n  = ST_LOCKED;
                                cnt_n    = '0;
                                miss_n   = '0;
                            end
                        end else begin
                            acq_n[lsb_idx] = sym[0];
                            cnt_n = cnt + 1'b1;
                        end
                    end
                end

                ST_LOCKED: begin
                    if (sym_valid) begin
                        shadow_n = shadow_step;
                        if (sym != shadow[REG_WIDTH-2 -: 2]) begin
                            err_pulse_n = 1'b1;
                            if (err_cnt != '1) begin
                                err_n = err_cnt + 1'b1;
                            end
                            if (miss_inc == MISS_W'(MISS_LIMIT)) begin
                                lost_n  = 1'b1;
                                state_n = ST_ACQUIRE;
                                acq_n   = '0;
                                cnt_n   = '0;
                                miss_n  = '0;
                            end else begin
                                miss_n = miss_inc;
                            end
                        end else begin
                            miss_n = '0;
                        end
                    end
                end

                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end

        if (clear) begin
            err_n = '0;
        end
    end

endmodule
